router_pkt_tx: RTL and testbench

Packet transmitter for the 1x3 router input port, sitting on the source side of the router's pkt_valid/data_in/busy/err interface.
A requester hands it a destination and a length, then streams in the payload bytes. The block buffers the whole payload, then drives header, payload and parity bytes with the router protocol timing, stalling whenever busy is high. It then samples the router's err output and reports per-packet completion status.

---
 rtl/router_pkt_tx_if.sv | 29 ++
 rtl/router_pkt_tx.sv | 173 +++++++++++++++++
 tb/tb_router_pkt_tx.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/router_pkt_tx_if.sv
// Handshake bundle between a packet requester / 1x3 router input port and router_pkt_tx.
// master = requester and router side, slave = the transmitter.
interface router_pkt_tx_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_addr;
    logic [5:0] req_len;
    logic       req_bad_parity;
    logic       pl_valid;
    logic       pl_ready;
    logic [7:0] pl_data;
    logic       pkt_valid;
    logic [7:0] pkt_data;
    logic       busy;
    logic       err;
    logic       done;
    logic       done_err;
    logic       rej;

    modport master (
        output req_valid, req_addr, req_len, req_bad_parity, pl_valid, pl_data, busy, err,
        input  req_ready, pl_ready, pkt_valid, pkt_data, done, done_err, rej
    );

    modport slave (
        input  req_valid, req_addr, req_len, req_bad_parity, pl_valid, pl_data, busy, err,
        output req_ready, pl_ready, pkt_valid, pkt_data, done, done_err, rej
    );
endinterface

// File: rtl/router_pkt_tx.sv
// Router packet transmitter: buffers a full payload, then sends header, payload and
// parity with busy back-pressure, and reports the router's err over a short window.
module router_pkt_tx #(
    parameter int MAX_LEN  = 63,
    parameter int ERR_WAIT = 3
) (
    input  logic           clock,
    input  logic           reset,
    router_pkt_tx_if.slave bus
);
    localparam int         CNT_W     = (ERR_WAIT > 1) ? $clog2(ERR_WAIT) : 1;
    localparam logic [5:0] MAX_LEN_L = 6'(MAX_LEN);

    typedef enum logic [2:0] {IDLE, LOAD, HEADER, PAYLOAD, PARITY, ERRCHK} state_t;

    state_t           state_q, state_d;
    logic [1:0]       addr_q;
    logic [5:0]       len_q;
    logic             bad_q;
    logic [5:0]       wr_ptr, rd_ptr;
    logic [7:0]       par_acc;
    logic [7:0]       pkt_data_q;
    logic             pkt_valid_q;
    logic             done_q, done_err_q, rej_q;
    logic             err_flag;
    logic [CNT_W-1:0] wait_cnt;
    logic [7:0]       buf_mem [MAX_LEN];

    logic             req_ready, pl_ready, xfer, req_legal, load_last, pay_last, wait_last;
    logic [7:0]       header;

    function automatic logic [7:0] parity_out(input logic [7:0] p, input logic inv);
        return inv ? ~p : p;
    endfunction

    assign header    = {len_q, addr_q};
    assign req_legal = (bus.req_addr != 2'd3) && (bus.req_len != 6'd0) && (bus.req_len <= MAX_LEN_L);
    assign load_last = bus.pl_valid && (wr_ptr == len_q - 6'd1);
    assign pay_last  = (rd_ptr == len_q);
    assign wait_last = (wait_cnt == CNT_W'(ERR_WAIT - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        pl_ready  = 1'b0;
        xfer      = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid && req_legal) state_d = LOAD;
            end
            LOAD: begin
                pl_ready = 1'b1;
                if (load_last) state_d = HEADER;
            end
            HEADER: begin
                xfer = !bus.busy;
                if (xfer) state_d = PAYLOAD;
            end
            PAYLOAD: begin
                xfer = !bus.busy;
                if (xfer && pay_last) state_d = PARITY;
            end
            PARITY: begin
                xfer = !bus.busy;
                if (xfer) state_d = ERRCHK;
            end
            ERRCHK: begin
                if (wait_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Payload store: data only, contents are don't-care outside a packet
    always_ff @(posedge clock) begin
        if (state_q == LOAD && bus.pl_valid) buf_mem[wr_ptr] <= bus.pl_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q      <= '0;
            len_q       <= '0;
            bad_q       <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            par_acc     <= '0;
            pkt_valid_q <= 1'b0;
            pkt_data_q  <= '0;
            done_q      <= 1'b0;
            done_err_q  <= 1'b0;
            rej_q       <= 1'b0;
            err_flag    <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            done_q <= 1'b0;
            rej_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        if (req_legal) begin
                            addr_q <= bus.req_addr;
                            len_q  <= bus.req_len;
                            bad_q  <= bus.req_bad_parity;
                            wr_ptr <= '0;
                            rd_ptr <= '0;
                        end else begin
                            rej_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (bus.pl_valid) begin
                        wr_ptr <= wr_ptr + 6'd1;
                        if (load_last) begin
                            pkt_valid_q <= 1'b1;
                            pkt_data_q  <= header;
                            par_acc     <= header;
                        end
                    end
                end
                HEADER: begin
                    if (xfer) begin
                        pkt_data_q <= buf_mem[0];
                        rd_ptr     <= 6'd1;
                    end
                end
                PAYLOAD: begin
                    // rd_ptr is the index of the byte after the one on the wire
                    if (xfer) begin
                        par_acc <= par_acc ^ pkt_data_q;
                        if (pay_last) begin
                            pkt_valid_q <= 1'b0;
                            pkt_data_q  <= parity_out(par_acc ^ pkt_data_q, bad_q);
                        end else begin
                            pkt_data_q <= buf_mem[rd_ptr];
                            rd_ptr     <= rd_ptr + 6'd1;
                        end
                    end
                end
                PARITY: begin
                    if (xfer) begin
                        wait_cnt <= '0;
                        err_flag <= 1'b0;
                    end
                end
                ERRCHK: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    err_flag <= err_flag | bus.err;
                    if (wait_last) begin
                        done_q     <= 1'b1;
                        done_err_q <= err_flag | bus.err;
                        err_flag   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.pl_ready  = pl_ready;
    assign bus.pkt_valid = pkt_valid_q;
    assign bus.pkt_data  = pkt_data_q;
    assign bus.done      = done_q;
    assign bus.done_err  = done_err_q;
    assign bus.rej       = rej_q;
endmodule

// File: tb/tb_router_pkt_tx.sv
// Randomized bench for router_pkt_tx: a byte-stream model (header, payload, parity)
// is advanced on every non-busy edge and compared with the DUT every cycle.
module tb_router_pkt_tx;
    localparam int MAX_LEN  = 63;
    localparam int ERR_WAIT = 3;

    logic clock = 1'b0;
    logic reset;

    router_pkt_tx_if bus ();

    router_pkt_tx #(.MAX_LEN(MAX_LEN), .ERR_WAIT(ERR_WAIT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int         n_vec  = 0;
    int         n_miss = 0;
    logic [7:0] payload [64];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.req_valid      = 1'b0;
        bus.req_addr       = 2'd0;
        bus.req_len        = 6'd0;
        bus.req_bad_parity = 1'b0;
        bus.pl_valid       = 1'b0;
        bus.pl_data        = 8'h00;
        bus.busy           = 1'b0;
        bus.err            = 1'b0;
    endtask

    // busy_mode: 0 never busy, 1 random busy, 2 busy for 2 cycles while byte stall_k is shown
    task automatic run_packet(input logic [1:0] addr, input int len, input logic bad,
                              input logic gaps, input int busy_mode, input int stall_k,
                              input int err_cyc, input int abort_k);
        logic [7:0] exp_b [66];
        logic [7:0] par;
        int         idx, k, cyc, stall_left;
        exp_b[0] = {6'(len), addr};
        par      = exp_b[0];
        for (int i = 0; i < len; i++) begin
            exp_b[i+1] = payload[i];
            par        = par ^ payload[i];
        end
        exp_b[len+1] = bad ? (8'hFF ^ par) : par;

        @(negedge clock);
        check_val("idle_req_ready", bus.req_ready, 1);
        bus.req_valid      = 1'b1;
        bus.req_addr       = addr;
        bus.req_len        = 6'(len);
        bus.req_bad_parity = bad;
        @(posedge clock);
        @(negedge clock);
        bus.req_valid = 1'b0;

        idx = 0;
        cyc = 0;
        while (idx < len) begin
            check_val("load_pl_ready", bus.pl_ready, 1);
            check_val("load_req_ready", bus.req_ready, 0);
            check_val("load_pkt_valid", bus.pkt_valid, 0);
            bus.req_valid = 1'($urandom_range(0, 1));
            bus.req_addr  = 2'($urandom);
            bus.req_len   = 6'($urandom);
            bus.pl_valid  = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.pl_data   = bus.pl_valid ? payload[idx] : 8'($urandom);
            @(posedge clock);
            if (bus.pl_valid) idx++;
            @(negedge clock);
            if (++cyc > 4000) begin
                check_val("load_timeout", idx, len);
                break;
            end
        end
        bus.pl_valid = 1'b0;

        k          = 0;
        cyc        = 0;
        stall_left = 2;
        while (k < len + 2) begin
            check_val("tx_valid", bus.pkt_valid, (k <= len) ? 1 : 0);
            check_val("tx_data", bus.pkt_data, exp_b[k]);
            check_val("tx_no_done", bus.done, 0);
            check_val("tx_req_ready", bus.req_ready, 0);
            check_val("tx_no_rej", bus.rej, 0);
            if (abort_k >= 0 && k == abort_k) begin
                #2 reset = 1'b1;
                #1;
                check_val("rst_pkt_valid", bus.pkt_valid, 0);
                check_val("rst_pkt_data", bus.pkt_data, 8'h00);
                check_val("rst_req_ready", bus.req_ready, 1);
                check_val("rst_pl_ready", bus.pl_ready, 0);
                idle_inputs();
                @(negedge clock);
                reset = 1'b0;
                for (int c = 0; c < 8; c++) begin
                    @(negedge clock);
                    check_val("post_rst_no_done", bus.done, 0);
                    check_val("post_rst_pkt_valid", bus.pkt_valid, 0);
                end
                return;
            end
            case (busy_mode)
                1:       bus.busy = ($urandom_range(0, 3) == 0);
                2: begin
                    bus.busy = (k == stall_k && stall_left > 0);
                    if (bus.busy) stall_left--;
                end
                default: bus.busy = 1'b0;
            endcase
            bus.req_valid = 1'($urandom_range(0, 1));
            bus.req_addr  = 2'($urandom);
            bus.req_len   = 6'($urandom);
            bus.pl_valid  = 1'($urandom_range(0, 1));
            bus.pl_data   = 8'($urandom);
            @(posedge clock);
            if (!bus.busy) k++;
            @(negedge clock);
            if (++cyc > 4000) begin
                check_val("tx_timeout", k, len + 2);
                break;
            end
        end
        idle_inputs();

        for (int c = 1; c <= ERR_WAIT; c++) begin
            check_val("errchk_no_done", bus.done, 0);
            check_val("errchk_pkt_valid", bus.pkt_valid, 0);
            bus.err = (c == err_cyc);
            @(posedge clock);
            @(negedge clock);
        end
        bus.err = 1'b0;
        check_val("done", bus.done, 1);
        check_val("done_err", bus.done_err, (err_cyc >= 1 && err_cyc <= ERR_WAIT) ? 1 : 0);
        check_val("done_req_ready", bus.req_ready, 1);
        @(negedge clock);
        check_val("done_pulse", bus.done, 0);
    endtask

    task automatic reject(input logic [1:0] addr, input logic [5:0] len);
        @(negedge clock);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_len   = len;
        bus.pl_valid  = 1'b1;
        bus.pl_data   = 8'hA5;
        @(posedge clock);
        @(negedge clock);
        check_val("rej_pulse", bus.rej, 1);
        check_val("rej_req_ready", bus.req_ready, 1);
        check_val("rej_pkt_valid", bus.pkt_valid, 0);
        check_val("rej_pl_ready", bus.pl_ready, 0);
        idle_inputs();
        @(negedge clock);
        check_val("rej_one_cycle", bus.rej, 0);
        check_val("rej_still_idle", bus.req_ready, 1);
        check_val("rej_no_pkt", bus.pkt_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check_val("reset_pkt_valid", bus.pkt_valid, 0);
        check_val("reset_pkt_data", bus.pkt_data, 8'h00);
        check_val("reset_done", bus.done, 0);
        check_val("reset_done_err", bus.done_err, 0);
        check_val("reset_rej", bus.rej, 0);
        check_val("reset_pl_ready", bus.pl_ready, 0);
        check_val("reset_req_ready", bus.req_ready, 1);
        reset = 1'b0;

        payload[0] = 8'h11; payload[1] = 8'h22; payload[2] = 8'h33;
        run_packet(2'd1, 3, 1'b0, 1'b0, 0, 0, 0, -1);
        run_packet(2'd1, 3, 1'b0, 1'b0, 2, 2, 0, -1);
        run_packet(2'd1, 3, 1'b1, 1'b0, 0, 0, 2, -1);

        reject(2'd3, 6'd5);
        reject(2'd0, 6'd0);

        for (int i = 0; i < MAX_LEN; i++) payload[i] = 8'(i);
        run_packet(2'd2, MAX_LEN, 1'b0, 1'b1, 0, 0, 0, -1);

        for (int i = 0; i < 8; i++) payload[i] = 8'($urandom);
        run_packet(2'd0, 8, 1'b0, 1'b0, 0, 0, 0, 3);
        payload[0] = 8'h5A;
        run_packet(2'd2, 1, 1'b0, 1'b0, 0, 0, 0, -1);

        for (int n = 0; n < 20; n++) begin
            int len;
            len = $urandom_range(1, MAX_LEN);
            for (int i = 0; i < len; i++) payload[i] = 8'($urandom);
            run_packet(2'($urandom_range(0, 2)), len, 1'($urandom_range(0, 1)), 1'b1, 1, 0,
                       $urandom_range(0, ERR_WAIT), -1);
            if (n % 5 == 4) reject(2'd3, 6'($urandom_range(0, 63)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
